// File: rtl/lcd_timing_gen.sv
// LCD timing generator with a serial sub-pixel data path.
// Each pixel occupies CHANNELS clocks and is sent as CHANNELS slices of DATA_W bits,
// most significant slice first. Sync/DE strobes, blanked data and frame/line strobes
// are registered one clock behind the counters; visible/vblank/x/y are combinational.
module lcd_timing_gen #(
    parameter int H_VISIBLE = 320,
    parameter int H_FRONT   = 20,
    parameter int H_SYNC    = 30,
    parameter int H_BACK    = 38,
    parameter int V_VISIBLE = 240,
    parameter int V_FRONT   = 4,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 15,
    parameter int CHANNELS  = 3,
    parameter int DATA_W    = 8,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int DE_POL    = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [CHANNELS*DATA_W-1:0]   rgb_data,
    output logic                         visible,
    output logic                         vblank,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [DATA_W-1:0]            lcd_dat,
    output logic                         lcd_hsync,
    output logic                         lcd_vsync,
    output logic                         lcd_den,
    output logic                         frame_start,
    output logic                         line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int HW1     = HW + 1;
    localparam int VW1     = VW + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // One extra bit so window ends equal to the total still compare correctly
    localparam logic [HW:0] H_VIS_E  = HW1'(H_VISIBLE);
    localparam logic [HW:0] HS_BEG   = HW1'(H_VISIBLE + H_FRONT);
    localparam logic [HW:0] HS_END   = HW1'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW:0] V_VIS_E  = VW1'(V_VISIBLE);
    localparam logic [VW:0] VS_BEG   = VW1'(V_VISIBLE + V_FRONT);
    localparam logic [VW:0] VS_END   = VW1'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);
    localparam logic DE_ACT = (DE_POL != 0);

    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;
    logic          ch_first;
    logic          pix_end;
    logic          hs_on;
    logic          vs_on;
    logic          fs_on;
    logic          ls_on;

    // Pixel/line counters: h_pos steps on the last channel, v_pos steps on h_pos wrap
    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_pos <= '0;
            v_pos <= '0;
        end else if (pix_end) begin
            if (h_pos == H_LAST) begin
                h_pos <= '0;
                v_pos <= (v_pos == V_LAST) ? '0 : v_pos + 1'b1;
            end else begin
                h_pos <= h_pos + 1'b1;
            end
        end
    end

    // Combinational position decode: visibility, coordinates and strobe conditions
    always_comb begin
        h_ext   = {1'b0, h_pos};
        v_ext   = {1'b0, v_pos};
        visible = (h_ext < H_VIS_E) && (v_ext < V_VIS_E);
        vblank  = (v_ext >= V_VIS_E);
        x       = visible ? X_W'(h_pos) : '0;
        y       = visible ? Y_W'(v_pos) : '0;
        hs_on   = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_on   = (v_ext >= VS_BEG) && (v_ext < VS_END);
        fs_on   = ch_first && (h_pos == '0) && (v_pos == '0);
        ls_on   = ch_first && (h_pos == '0) && (v_ext < V_VIS_E);
    end

    // Registered panel strobes, one clock behind the counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lcd_hsync   <= ~HS_ACT;
            lcd_vsync   <= ~VS_ACT;
            lcd_den     <= ~DE_ACT;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            lcd_hsync   <= hs_on   ? HS_ACT : ~HS_ACT;
            lcd_vsync   <= vs_on   ? VS_ACT : ~VS_ACT;
            lcd_den     <= visible ? DE_ACT : ~DE_ACT;
            frame_start <= fs_on;
            line_start  <= ls_on;
        end
    end

    generate
        if (CHANNELS > 1) begin : g_multi
            localparam int CW = $clog2(CHANNELS);
            localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

            logic [CW-1:0]              chan;
            logic [CHANNELS*DATA_W-1:0] pix_q;
            logic [DATA_W-1:0]          slice;

            assign ch_first = (chan == '0);
            assign pix_end  = (chan == CH_LAST);

            // Sub-pixel channel counter
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    chan <= '0;
                end else begin
                    chan <= pix_end ? '0 : chan + 1'b1;
                end
            end

            // Select the captured slice for the current channel, MS slice on channel 0
            always_comb begin
                slice = '0;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    if (chan == CW'(k)) begin
                        slice = pix_q[(CHANNELS - 1 - k)*DATA_W +: DATA_W];
                    end
                end
            end

            // Channel 0 sends the live MS slice and captures the word; later channels replay it
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    lcd_dat <= '0;
                    pix_q   <= '0;
                end else if (visible) begin
                    if (ch_first) begin
                        lcd_dat <= rgb_data[CHANNELS*DATA_W-1 -: DATA_W];
                        pix_q   <= rgb_data;
                    end else begin
                        lcd_dat <= slice;
                    end
                end else begin
                    lcd_dat <= '0;
                end
            end
        end else begin : g_single
            assign ch_first = 1'b1;
            assign pix_end  = 1'b1;

            // One clock per pixel: the word passes straight through, blanked outside the window
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    lcd_dat <= '0;
                end else begin
                    lcd_dat <= visible ? rgb_data[CHANNELS*DATA_W-1 -: DATA_W] : '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small geometry (H 4/1/2/1, V 3/1/1/1).
// Main instance: CHANNELS 3, DATA_W 8, active-low strobes (frame = 144 clk).
// Second instance: CHANNELS 1, DATA_W 24, active-high DE (frame = 48 clk).
module tb_lcd_timing_gen;

    logic        clk;
    logic        resetn;
    logic [23:0] rgb;
    logic        visible, vblank;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  dat;
    logic        hs, vs, den, fs, ls;

    logic        resetn1;
    logic [23:0] rgb1;
    logic        visible1, vblank1;
    logic [8:0]  x1;
    logic [7:0]  y1;
    logic [23:0] dat1;
    logic        hs1, vs1, den1, fs1, ls1;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    lcd_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CHANNELS(3), .DATA_W(8), .X_W(9), .Y_W(8),
        .HSYNC_POL(0), .VSYNC_POL(0), .DE_POL(0)
    ) u_dut (
        .clk(clk), .resetn(resetn), .rgb_data(rgb),
        .visible(visible), .vblank(vblank), .x(x), .y(y),
        .lcd_dat(dat), .lcd_hsync(hs), .lcd_vsync(vs), .lcd_den(den),
        .frame_start(fs), .line_start(ls)
    );

    lcd_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CHANNELS(1), .DATA_W(24), .X_W(9), .Y_W(8),
        .HSYNC_POL(0), .VSYNC_POL(0), .DE_POL(1)
    ) u_dut1 (
        .clk(clk), .resetn(resetn1), .rgb_data(rgb1),
        .visible(visible1), .vblank(vblank1), .x(x1), .y(y1),
        .lcd_dat(dat1), .lcd_hsync(hs1), .lcd_vsync(vs1), .lcd_den(den1),
        .frame_start(fs1), .line_start(ls1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    int hs_low, vs_low, fs_cnt, last_fs, first_vs, hs_line, den_line;
    int den1_line, fs1_cnt;

    initial begin
        resetn  = 1'b0;
        rgb     = 24'hA1B2C3;
        resetn1 = 1'b0;
        rgb1    = 24'h000000;
        hs_low = 0; vs_low = 0; fs_cnt = 0; last_fs = 0; first_vs = 0;
        hs_line = 0; den_line = 0; den1_line = 0; fs1_cnt = 0;

        tick();
        tick();
        chk("rst_dat", dat, 8'h00);
        chk("rst_fs", fs, 1'b0);
        chk("rst_ls", ls, 1'b0);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_den", den, 1'b1);
        chk("rst_visible", visible, 1'b1);

        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 290; i++) begin
            tick();
            if (n <= 288) begin
                if (hs == 1'b0) hs_low++;
                if (vs == 1'b0) begin
                    vs_low++;
                    if (first_vs == 0) first_vs = n;
                end
                if (fs == 1'b1) begin
                    fs_cnt++;
                    last_fs = n;
                end
            end
            if (n <= 24) begin
                if (hs == 1'b0) hs_line++;
                if (den == 1'b0) den_line++;
            end
            case (n)
                1: begin
                    chk("c1_fs", fs, 1'b1);
                    chk("c1_ls", ls, 1'b1);
                    chk("c1_dat", dat, 8'hA1);
                    chk("c1_den", den, 1'b0);
                    chk("c1_hs", hs, 1'b1);
                    chk("c1_vs", vs, 1'b1);
                    rgb = 24'h000000;
                end
                2: begin
                    chk("c2_dat_pixq", dat, 8'hB2);
                    chk("c2_fs", fs, 1'b0);
                    chk("c2_ls", ls, 1'b0);
                end
                3: begin
                    chk("c3_dat_pixq", dat, 8'hC3);
                    rgb = 24'h112233;
                end
                4: begin
                    chk("c4_dat", dat, 8'h11);
                    chk("c4_x", x, 9'd1);
                end
                5: chk("c5_dat", dat, 8'h22);
                12: begin
                    chk("c12_dat_last", dat, 8'h33);
                    chk("c12_den", den, 1'b0);
                    rgb = 24'hFFFFFF;
                end
                13: begin
                    chk("c13_dat_blank", dat, 8'h00);
                    chk("c13_den", den, 1'b1);
                    chk("c13_visible", visible, 1'b0);
                    chk("c13_x", x, 9'd0);
                    chk("c13_vblank", vblank, 1'b0);
                end
                15: chk("c15_hs", hs, 1'b1);
                16: chk("c16_hs", hs, 1'b0);
                18: begin
                    chk("c18_dat_hblank", dat, 8'h00);
                    chk("c18_den", den, 1'b1);
                end
                21: chk("c21_hs", hs, 1'b0);
                22: chk("c22_hs", hs, 1'b1);
                25: begin
                    chk("c25_ls", ls, 1'b1);
                    chk("c25_fs", fs, 1'b0);
                    chk("c25_dat", dat, 8'hFF);
                    chk("c25_den", den, 1'b0);
                    chk("c25_y", y, 8'd1);
                end
                49: chk("c49_ls", ls, 1'b1);
                71: begin
                    chk("c71_vblank", vblank, 1'b0);
                    chk("c71_visible", visible, 1'b0);
                end
                72: chk("c72_vblank", vblank, 1'b1);
                73: begin
                    chk("c73_den", den, 1'b1);
                    chk("c73_dat", dat, 8'h00);
                    chk("c73_ls", ls, 1'b0);
                end
                80: begin
                    chk("c80_visible", visible, 1'b0);
                    chk("c80_x", x, 9'd0);
                    chk("c80_y", y, 8'd0);
                    chk("c80_vblank", vblank, 1'b1);
                end
                96: chk("c96_vs", vs, 1'b1);
                97: chk("c97_vs", vs, 1'b0);
                145: begin
                    chk("c145_fs", fs, 1'b1);
                    chk("c145_ls", ls, 1'b1);
                    chk("c145_dat", dat, 8'hFF);
                end
                default: ;
            endcase
        end

        chk("hs_low_line", hs_line, 6);
        chk("den_low_line", den_line, 12);
        chk("hs_low_2frames", hs_low, 72);
        chk("vs_low_2frames", vs_low, 48);
        chk("first_vs", first_vs, 97);
        chk("fs_count", fs_cnt, 2);
        chk("fs_period", last_fs, 145);

        // mid-pixel reset at h_pos 2 channel 1
        while (n < 295) tick();
        chk("pre_rst_den", den, 1'b0);
        chk("pre_rst_dat", dat, 8'hFF);
        resetn = 1'b0;
        tick();
        chk("mid_rst_dat", dat, 8'h00);
        chk("mid_rst_den", den, 1'b1);
        chk("mid_rst_hs", hs, 1'b1);
        chk("mid_rst_vs", vs, 1'b1);
        chk("mid_rst_fs", fs, 1'b0);
        chk("mid_rst_ls", ls, 1'b0);
        resetn = 1'b1;
        tick();
        chk("post_rst_fs", fs, 1'b1);
        chk("post_rst_ls", ls, 1'b1);
        chk("post_rst_dat", dat, 8'hFF);
        chk("post_rst_den", den, 1'b0);
        tick();
        chk("post_rst_fs_drop", fs, 1'b0);

        // single-channel instance, active-high DE
        chk("s_rst_dat", dat1, 24'h000000);
        chk("s_rst_den", den1, 1'b0);
        chk("s_rst_hs", hs1, 1'b1);
        chk("s_rst_fs", fs1, 1'b0);
        rgb1    = 24'h100001;
        resetn1 = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k <= 8 && den1 == 1'b1) den1_line++;
            if (k <= 48 && fs1 == 1'b1) fs1_cnt++;
            case (k)
                1: begin
                    chk("s1_dat", dat1, 24'h100001);
                    chk("s1_den", den1, 1'b1);
                    chk("s1_fs", fs1, 1'b1);
                    chk("s1_ls", ls1, 1'b1);
                end
                4: chk("s4_dat", dat1, 24'h100004);
                5: begin
                    chk("s5_dat", dat1, 24'h000000);
                    chk("s5_den", den1, 1'b0);
                end
                9: begin
                    chk("s9_dat", dat1, 24'h100009);
                    chk("s9_ls", ls1, 1'b1);
                    chk("s9_fs", fs1, 1'b0);
                end
                25: begin
                    chk("s25_dat", dat1, 24'h000000);
                    chk("s25_ls", ls1, 1'b0);
                end
                49: begin
                    chk("s49_fs", fs1, 1'b1);
                    chk("s49_dat", dat1, 24'h100031);
                end
                default: ;
            endcase
            rgb1 = 24'h100000 + 24'(k + 1);
        end
        chk("s_den_line", den1_line, 4);
        chk("s_fs_count", fs1_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
